// File: rtl/seq_ctrl_gen2_if.sv
// Controller-side bundle for seq_ctrl_gen2: IR fields, ALU flags and run enable in,
// datapath/RAM/port strobes out.
`timescale 1ns/1ps
interface seq_ctrl_gen2_if #(
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned NUM_PORTS = 4
);
  logic                 EN;
  logic [ADDR_W-1:0]    ADDR;
  logic [3:0]           OPCODE;
  logic                 I_FLAG;
  logic                 ZF;
  logic                 NF;
  logic                 OF;
  logic                 CF;

  logic                 IR_EN;
  logic                 A_EN;
  logic                 B_EN;
  logic                 PDR_EN;
  logic                 PORT_EN;
  logic                 PORT_RD;
  logic                 PC_EN;
  logic                 PC_LOAD;
  logic                 ALU_EN;
  logic                 ALU_OE;
  logic                 RAM_OE;
  logic                 RDR_EN;
  logic                 RAM_CS;
  logic [NUM_PORTS-1:0] PORT_SEL;
  logic                 HALTED;

  modport master (
    output EN, ADDR, OPCODE, I_FLAG, ZF, NF, OF, CF,
    input  IR_EN, A_EN, B_EN, PDR_EN, PORT_EN, PORT_RD, PC_EN, PC_LOAD,
           ALU_EN, ALU_OE, RAM_OE, RDR_EN, RAM_CS, PORT_SEL, HALTED
  );

  modport slave (
    input  EN, ADDR, OPCODE, I_FLAG, ZF, NF, OF, CF,
    output IR_EN, A_EN, B_EN, PDR_EN, PORT_EN, PORT_RD, PC_EN, PC_LOAD,
           ALU_EN, ALU_OE, RAM_OE, RDR_EN, RAM_CS, PORT_SEL, HALTED
  );
endinterface

// File: rtl/seq_ctrl_gen2.sv
// Second-generation accumulator-CPU sequence controller: fetch/decode/operand/ALU/
// write-back/branch phases with RAM wait states, an I/O port window and a sticky halt.
`timescale 1ns/1ps
module seq_ctrl_gen2 #(
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned PORT_BASE = 64,
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned MEM_WAIT  = 0
) (
  input  logic           CLK,
  input  logic           RST,
  seq_ctrl_gen2_if.slave bus
);

  localparam int unsigned CNT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_OPER,
    S_WB,
    S_ALU,
    S_BRANCH,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_LOAD  = 4'd0,
    OP_STORE = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_XOR   = 4'd6,
    OP_NOT   = 4'd7,
    OP_B     = 4'd8,
    OP_BZ    = 4'd9,
    OP_BN    = 4'd10,
    OP_BV    = 4'd11,
    OP_BC    = 4'd12
  } op_e;

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic ir_en, a_en, b_en, pdr_en, port_en, port_rd, pc_en, pc_load;
  logic alu_en, alu_oe, ram_oe, rdr_en, ram_cs;

  op_e                  op;
  logic                 is_load;
  logic                 is_store;
  logic                 last_beat;
  logic                 run;
  logic [31:0]          addr_ext;
  logic [NUM_PORTS-1:0] port_sel_raw;
  logic                 port_hit;

  assign op        = op_e'(bus.OPCODE);
  assign is_load   = (op == OP_LOAD);
  assign is_store  = (op == OP_STORE);
  assign last_beat = (cnt == CNT_LAST);
  assign run       = ~RST & bus.EN;
  assign addr_ext  = 32'(bus.ADDR);

  always_comb begin
    port_sel_raw = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      port_sel_raw[i] = (addr_ext == PORT_BASE + i);
    end
  end

  assign port_hit = |port_sel_raw;

  // EN=0 freezes both the phase and the wait counter so execution resumes exactly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (bus.EN) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ir_en     = 1'b0;
    a_en      = 1'b0;
    b_en      = 1'b0;
    pdr_en    = 1'b0;
    port_en   = 1'b0;
    port_rd   = 1'b0;
    pc_en     = 1'b0;
    pc_load   = 1'b0;
    alu_en    = 1'b0;
    alu_oe    = 1'b0;
    ram_oe    = 1'b0;
    rdr_en    = 1'b0;
    ram_cs    = 1'b0;

    case (state)
      S_IDLE: begin
        state_nxt = S_FETCH;
      end

      S_FETCH: begin
        ram_cs = 1'b1;
        ram_oe = 1'b1;
        if (last_beat) begin
          ir_en     = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_DECODE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      S_DECODE: begin
        pc_en = 1'b1;
        if ((bus.OPCODE > 4'd12) || (is_store && bus.I_FLAG)) begin
          state_nxt = S_HALT;
        end else if (op == OP_NOT) begin
          state_nxt = S_ALU;
        end else if (bus.OPCODE >= 4'd8) begin
          state_nxt = S_BRANCH;
        end else begin
          state_nxt = S_OPER;
        end
      end

      S_OPER: begin
        if (bus.I_FLAG) begin
          // Immediate STORE never reaches here; it halts in DECODE.
          if (is_load) begin
            a_en      = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            b_en      = 1'b1;
            state_nxt = S_ALU;
          end
        end else if (port_hit) begin
          port_en = 1'b1;
          pdr_en  = 1'b1;
          if (is_store) begin
            state_nxt = S_FETCH;
          end else begin
            port_rd   = 1'b1;
            state_nxt = S_WB;
          end
        end else begin
          ram_cs = 1'b1;
          ram_oe = ~is_store;
          if (last_beat) begin
            rdr_en    = ~is_store;
            cnt_nxt   = '0;
            state_nxt = is_store ? S_FETCH : S_WB;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end

      S_WB: begin
        if (is_load) begin
          a_en      = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          b_en      = 1'b1;
          state_nxt = S_ALU;
        end
      end

      S_ALU: begin
        alu_en    = 1'b1;
        alu_oe    = 1'b1;
        a_en      = 1'b1;
        state_nxt = S_FETCH;
      end

      S_BRANCH: begin
        case (op)
          OP_B:    pc_load = 1'b1;
          OP_BZ:   pc_load = bus.ZF;
          OP_BN:   pc_load = bus.NF;
          OP_BV:   pc_load = bus.OF;
          OP_BC:   pc_load = bus.CF;
          default: pc_load = 1'b0;
        endcase
        state_nxt = S_FETCH;
      end

      S_HALT: begin
        state_nxt = S_HALT;
      end

      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.IR_EN    = run & ir_en;
  assign bus.A_EN     = run & a_en;
  assign bus.B_EN     = run & b_en;
  assign bus.PDR_EN   = run & pdr_en;
  assign bus.PORT_EN  = run & port_en;
  assign bus.PORT_RD  = run & port_rd;
  assign bus.PC_EN    = run & pc_en;
  assign bus.PC_LOAD  = run & pc_load;
  assign bus.ALU_EN   = run & alu_en;
  assign bus.ALU_OE   = run & alu_oe;
  assign bus.RAM_OE   = run & ram_oe;
  assign bus.RDR_EN   = run & rdr_en;
  assign bus.RAM_CS   = run & ram_cs;
  assign bus.PORT_SEL = (run & port_en) ? port_sel_raw : '0;
  assign bus.HALTED   = run & (state == S_HALT);

endmodule

// File: tb/tb_seq_ctrl_gen2.sv
// Directed bench for seq_ctrl_gen2: one instance with MEM_WAIT=0 and one with MEM_WAIT=2,
// per-cycle expected strobe vectors queued at drive time and checked at the falling edge.
`timescale 1ns/1ps
module tb_seq_ctrl_gen2;

  typedef logic [17:0] vec_t;  // [17:14] PORT_SEL, [13:0] strobes

  localparam vec_t IR  = 18'h02000;
  localparam vec_t AE  = 18'h01000;
  localparam vec_t BE  = 18'h00800;
  localparam vec_t PDR = 18'h00400;
  localparam vec_t PE  = 18'h00200;
  localparam vec_t PRD = 18'h00100;
  localparam vec_t PCE = 18'h00080;
  localparam vec_t PCL = 18'h00040;
  localparam vec_t ALE = 18'h00020;
  localparam vec_t ALO = 18'h00010;
  localparam vec_t ROE = 18'h00008;
  localparam vec_t RDR = 18'h00004;
  localparam vec_t RCS = 18'h00002;
  localparam vec_t HLT = 18'h00001;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  seq_ctrl_gen2_if #(.ADDR_W(7), .NUM_PORTS(4)) a_if ();
  seq_ctrl_gen2_if #(.ADDR_W(7), .NUM_PORTS(4)) b_if ();

  seq_ctrl_gen2 #(.ADDR_W(7), .PORT_BASE(64), .NUM_PORTS(4), .MEM_WAIT(0)) u_a (
    .CLK(CLK), .RST(RST), .bus(a_if)
  );
  seq_ctrl_gen2 #(.ADDR_W(7), .PORT_BASE(64), .NUM_PORTS(4), .MEM_WAIT(2)) u_b (
    .CLK(CLK), .RST(RST), .bus(b_if)
  );

  always #5 CLK = ~CLK;

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t exp_q[$];
  int   dut_q[$];
  string tag_q[$];

  function automatic vec_t psel(input int p);
    vec_t v;
    v = '0;
    v[14 + p] = 1'b1;
    return v;
  endfunction

  function automatic vec_t obs(input int d);
    if (d == 0)
      return {a_if.PORT_SEL, a_if.IR_EN, a_if.A_EN, a_if.B_EN, a_if.PDR_EN, a_if.PORT_EN,
              a_if.PORT_RD, a_if.PC_EN, a_if.PC_LOAD, a_if.ALU_EN, a_if.ALU_OE, a_if.RAM_OE,
              a_if.RDR_EN, a_if.RAM_CS, a_if.HALTED};
    return {b_if.PORT_SEL, b_if.IR_EN, b_if.A_EN, b_if.B_EN, b_if.PDR_EN, b_if.PORT_EN,
            b_if.PORT_RD, b_if.PC_EN, b_if.PC_LOAD, b_if.ALU_EN, b_if.ALU_OE, b_if.RAM_OE,
            b_if.RDR_EN, b_if.RAM_CS, b_if.HALTED};
  endfunction

  // One clock cycle: queue the expectation, compare mid-cycle, leave 1ns after the next edge.
  task automatic step(input string tag, input int d, input vec_t e);
    vec_t  o, ex;
    int    dd;
    string tg;
    exp_q.push_back(e);
    dut_q.push_back(d);
    tag_q.push_back(tag);
    @(negedge CLK);
    ex = exp_q.pop_front();
    dd = dut_q.pop_front();
    tg = tag_q.pop_front();
    o  = obs(dd);
    n_cmp++;
    assert (o === ex) else begin
      n_err++;
      $error("FAIL %s dut%0d observed=%05h expected=%05h", tg, dd, o, ex);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic instr(input int d, input logic [3:0] op, input logic ifl, input logic [6:0] addr);
    if (d == 0) begin
      a_if.OPCODE = op; a_if.I_FLAG = ifl; a_if.ADDR = addr;
    end else begin
      b_if.OPCODE = op; b_if.I_FLAG = ifl; b_if.ADDR = addr;
    end
  endtask

  task automatic fetch_decode(input int d);
    int mw;
    mw = (d == 0) ? 0 : 2;
    for (int i = 0; i <= mw; i++) step("fetch", d, (i == mw) ? (RCS | ROE | IR) : (RCS | ROE));
    step("decode", d, PCE);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    {a_if.EN, a_if.ZF, a_if.NF, a_if.OF, a_if.CF} = '0;
    {b_if.EN, b_if.ZF, b_if.NF, b_if.OF, b_if.CF} = '0;
    instr(1, 4'd0, 1'b0, 7'd0);

    // Reset with EN=1, LOAD immediate; then the 3-cycle LOAD-imm loop
    a_if.EN = 1'b1;
    instr(0, 4'd0, 1'b1, 7'd5);
    @(posedge CLK); #1;
    step("rst0", 0, '0);
    step("rst1", 0, '0);
    RST = 1'b0;
    step("idle", 0, '0);
    fetch_decode(0);
    step("ldi_oper", 0, AE);
    fetch_decode(0);
    step("ldi_oper2", 0, AE);

    // Port window: LOAD then STORE on each port, then the first address past the window
    for (int p = 0; p < 4; p++) begin
      instr(0, 4'd0, 1'b0, 7'(64 + p));
      fetch_decode(0);
      step("port_ld", 0, PE | PDR | PRD | psel(p));
      step("port_ld_wb", 0, AE);
      instr(0, 4'd1, 1'b0, 7'(64 + p));
      fetch_decode(0);
      step("port_st", 0, PE | PDR | psel(p));
    end
    instr(0, 4'd0, 1'b0, 7'd68);
    fetch_decode(0);
    step("ram68_ld", 0, RCS | ROE | RDR);
    step("ram68_wb", 0, AE);
    instr(0, 4'd1, 1'b0, 7'd63);
    fetch_decode(0);
    step("ram63_st", 0, RCS);

    // Branches against each single flag (f=0 none, 1 ZF, 2 NF, 3 OF, 4 CF)
    for (int op = 8; op <= 12; op++) begin
      for (int f = 0; f <= 4; f++) begin
        instr(0, 4'(op), 1'b0, 7'd3);
        a_if.ZF = (f == 1); a_if.NF = (f == 2); a_if.OF = (f == 3); a_if.CF = (f == 4);
        fetch_decode(0);
        step("branch", 0, ((op == 8) || (op - 8 == f)) ? PCL : '0);
      end
    end
    {a_if.ZF, a_if.NF, a_if.OF, a_if.CF} = '0;

    // ALU RAM, ALU immediate, NOT
    instr(0, 4'd2, 1'b0, 7'd20);
    fetch_decode(0);
    step("add_oper", 0, RCS | ROE | RDR);
    step("add_wb", 0, BE);
    step("add_alu", 0, ALE | ALO | AE);
    instr(0, 4'd3, 1'b1, 7'd9);
    fetch_decode(0);
    step("subi_oper", 0, BE);
    step("subi_alu", 0, ALE | ALO | AE);
    instr(0, 4'd7, 1'b0, 7'd0);
    fetch_decode(0);
    step("not_alu", 0, ALE | ALO | AE);

    // Illegal opcode: sticky halt, gated off by EN=0, cleared by reset
    instr(0, 4'd13, 1'b0, 7'd0);
    fetch_decode(0);
    for (int i = 0; i < 10; i++) step("halt13", 0, HLT);
    a_if.EN = 1'b0;
    step("halt_en0", 0, '0);
    a_if.EN = 1'b1;
    step("halt_resume", 0, HLT);
    RST = 1'b1;
    step("halt_rst", 0, '0);
    RST = 1'b0;
    step("halt_idle", 0, '0);
    instr(0, 4'd1, 1'b1, 7'd0);
    fetch_decode(0);
    for (int i = 0; i < 3; i++) step("halt_sti", 0, HLT);
    RST = 1'b1;
    step("halt_rst2", 0, '0);
    RST = 1'b0;
    a_if.EN = 1'b0;

    // MEM_WAIT=2: LOAD from RAM, 8 cycles from IDLE
    b_if.EN = 1'b1;
    instr(1, 4'd0, 1'b0, 7'd10);
    step("mw_idle", 1, '0);
    fetch_decode(1);
    step("mw_ld_op0", 1, RCS | ROE);
    step("mw_ld_op1", 1, RCS | ROE);
    step("mw_ld_op2", 1, RCS | ROE | RDR);
    step("mw_ld_wb", 1, AE);

    // ADD from RAM with EN dropped for 3 cycles after the first OPER beat
    instr(1, 4'd2, 1'b0, 7'd20);
    fetch_decode(1);
    step("mw_add_op0", 1, RCS | ROE);
    b_if.EN = 1'b0;
    for (int i = 0; i < 3; i++) step("mw_add_frozen", 1, '0);
    b_if.EN = 1'b1;
    step("mw_add_op1", 1, RCS | ROE);
    step("mw_add_op2", 1, RCS | ROE | RDR);
    step("mw_add_wb", 1, BE);
    step("mw_add_alu", 1, ALE | ALO | AE);

    // STORE to RAM: chip select only, no output enable or read strobe
    instr(1, 4'd1, 1'b0, 7'd30);
    fetch_decode(1);
    for (int i = 0; i < 3; i++) step("mw_st_op", 1, RCS);

    // Port access stays single cycle regardless of wait states
    instr(1, 4'd0, 1'b0, 7'd65);
    fetch_decode(1);
    step("mw_port_ld", 1, PE | PDR | PRD | psel(1));
    step("mw_port_wb", 1, AE);

    // Reset during the second fetch beat: counter must restart from zero
    step("mw_rf0", 1, RCS | ROE);
    RST = 1'b1;
    step("mw_rf_rst", 1, '0);
    RST = 1'b0;
    step("mw_rf_idle", 1, '0);
    fetch_decode(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_ctrl_gen2.md
Name: seq_ctrl_gen2

Overview:
Parametrised second-generation sequence controller for the accumulator CPU. It decodes OPCODE, I_FLAG, ADDR and the ALU flags into the datapath, RAM and I/O-port enable strobes. It sequences fetch, decode, operand, ALU, write-back and branch phases. New in this generation:
- RAM wait states, configurable per build.
- Parametrised port window with one-hot port select.
- Explicit idle and halt states, with halt on an illegal instruction.

Parameters:
ADDR_W, 7, operand address width.
PORT_BASE, 64, first address of the I/O port window.
NUM_PORTS, 4, number of ports in the window (1..16).
MEM_WAIT, 0, extra RAM cycles per access (0..7); every RAM access lasts MEM_WAIT+1 cycles.

Ports:
CLK  in  1  clock; all state changes on the rising edge.
RST  in  1  synchronous, active-high reset.
EN  in  1  run enable; 0 freezes state and forces all strobes to 0.
ADDR  in  ADDR_W  operand address field of IR.
OPCODE  in  4  0 LOAD, 1 STORE, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 B, 9 BZ, 10 BN, 11 BV, 12 BC; 13-15 illegal.
I_FLAG  in  1  immediate operand.
ZF, NF, OF, CF  in  1 each  ALU flags.
IR_EN, A_EN, B_EN, PDR_EN, PORT_EN, PORT_RD, PC_EN, PC_LOAD, ALU_EN, ALU_OE, RAM_OE, RDR_EN, RAM_CS  out  1 each  datapath strobes, active-high.
PORT_SEL  out  NUM_PORTS  one-hot port select; bit = ADDR-PORT_BASE.
HALTED  out  1  controller is in HALT.

Behaviour:
- States: IDLE, FETCH, DECODE, OPER, WB, ALU, BRANCH, HALT. A wait counter (0..MEM_WAIT) is used in FETCH and OPER.
- Reset:
  - On the edge with RST=1: state=IDLE, counter=0.
  - Strobe outputs are combinational from state and inputs, and are gated to 0 whenever RST=1 or EN=0. HALTED is also 0 during those cycles.
  - After reset, all outputs are 0 until the first FETCH.
- EN=0: state and counter hold and all strobes are 0. Execution resumes in the same state and counter value when EN returns to 1.
- Port hit: PORT_BASE <= ADDR <= PORT_BASE+NUM_PORTS-1. Any other address is RAM. PORT_SEL is all-zero unless PORT_EN=1.
- IDLE: outputs 0. Goes to FETCH on the next edge when EN=1.
- FETCH: RAM_CS=1, RAM_OE=1 for MEM_WAIT+1 cycles. IR_EN=1 on the final cycle only, then go to DECODE.
- DECODE: PC_EN=1 for one cycle. Next state:
  - OPCODE>12, or STORE with I_FLAG=1: HALT.
  - NOT: ALU.
  - B..BC: BRANCH.
  - Otherwise: OPER.
- OPER, immediate (I_FLAG=1): LOAD gives A_EN=1, then FETCH. ALU op gives B_EN=1, then ALU. Single cycle.
- OPER, port:
  - Both directions: PORT_EN=1, PDR_EN=1, PORT_SEL valid. Single cycle.
  - Read (LOAD, ALU op): PORT_RD=1, then WB.
  - STORE: PORT_RD=0, then FETCH.
- OPER, RAM:
  - RAM_CS=1 for MEM_WAIT+1 cycles.
  - Read: RAM_OE=1 throughout, RDR_EN=1 on the final cycle, then WB.
  - STORE: RAM_OE=0 throughout, then FETCH.
- WB: LOAD gives A_EN=1, then FETCH. ALU op gives B_EN=1, then ALU. Single cycle.
- ALU: ALU_EN=1, ALU_OE=1, A_EN=1 for one cycle, then FETCH.
- BRANCH: PC_LOAD is 1 for B, ZF for BZ, NF for BN, OF for BV, CF for BC. Flags are sampled in this cycle. One cycle, then FETCH.
- HALT: HALTED=1, all strobes 0. Sticky until RST.
- Cycle counts, MEM_WAIT=0:
  - LOAD imm 3.
  - LOAD RAM or port 4.
  - STORE 3.
  - ALU imm 4.
  - ALU RAM or port 5.
  - NOT 3.
  - Branch 3.
  - Each RAM access adds MEM_WAIT cycles.
- Reset mid-access: counter clears and state returns to IDLE; no strobe is issued on the reset cycle.
- The counter never exceeds MEM_WAIT. With MEM_WAIT=0 the counter is unused.

Test Plan:
1. RST=1 for 2 cycles then EN=1, OPCODE=0, I_FLAG=1 -> all outputs 0 during reset. Then IDLE, then FETCH (RAM_CS, RAM_OE, IR_EN), DECODE (PC_EN), OPER (A_EN), then FETCH again: 3-cycle loop.
2. MEM_WAIT=2, LOAD, I_FLAG=0, ADDR=10 -> FETCH holds RAM_CS/RAM_OE for 3 cycles with IR_EN on the 3rd only. OPER likewise with RDR_EN on the 3rd. WB gives A_EN. Total 8 cycles.
3. ADDR=64..67, LOAD then STORE, I_FLAG=0 -> PORT_SEL=0001, 0010, 0100, 1000. PORT_RD=1 for LOAD and 0 for STORE. PDR_EN=1. ADDR=68 takes the RAM path with PORT_EN=0.
4. OPCODE=8..12 with flags all 0, then each flag set singly -> PC_LOAD=1 only for B and for the matching flag. PC_EN=1 in every DECODE.
5. ADD, I_FLAG=0, ADDR=20 -> OPER (RDR_EN), WB (B_EN), ALU (ALU_EN, ALU_OE, A_EN). Drop EN to 0 for 3 cycles mid-OPER -> strobes 0, state resumes unchanged.
6. OPCODE=13 (and separately STORE with I_FLAG=1) -> HALTED=1 after DECODE, strobes stay 0 for 10 cycles. RST then returns to IDLE.
